i2s_multi_mic_receiver: RTL and testbench
=========================================

// Module: i2s_multi_mic_receiver
// PURPOSE
//  I2S master receiver for up to n_lines INMP441-class mic data lines. Generates sck/ws from clk and
//  captures left and right slots per line; stereo mode means two mics per line, strapped L/R.
//  Presents all channels as signed samples with a common valid strobe and per-channel peak magnitude.
//  Sits between the board GPIO pins and top, replacing the single-mic 24-bit receiver.
// PARAMETERS
//  sck_half_period  8   clk cycles per sck half period (>=2); sck = clk/(2*sck_half_period)
//  n_lines          2   number of sd data lines (>=1)
//  w_sample         24  captured bits per slot, MSB first, two's complement
//  slot_bits        32  sck cycles per slot (>= w_sample+1); frame = 2*slot_bits sck cycles
//  stereo           1   1: capture L and R slots (2*n_lines channels); 0: L slot only (n_lines channels)
// PORTS
//  clk          in   1                   system clock
//  rst_n        in   1                   asynchronous active-low reset
//  sck          out  1                   I2S bit clock to mics
//  ws           out  1                   I2S word select; 0 = left slot, 1 = right slot
//  sd           in   n_lines             serial data from mics, one bit per line
//  peak_clr     in   1                   synchronous clear of all peak registers
//  sample       out  n_ch*w_sample       channel c at [c*w_sample +: w_sample]; n_ch = n_lines*(stereo?2:1)
//  sample_valid out  1                   one-clk pulse: all sample lanes updated together
//  peak         out  n_ch*(w_sample-1)   per-channel max |sample| since last clear, unsigned
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): sck=0, ws=0, sample=0, sample_valid=0, peak=0, all counters 0.
//  Divider: div_cnt counts 0..sck_half_period-1; at wrap sck toggles. rise_ev = wrap with sck==0;
//   fall_ev = wrap with sck==1. All sampling/shifting happens on clk edges qualified by these events.
//  Bit counter: bit_cnt 0..2*slot_bits-1, advances on fall_ev, wraps to 0. ws = (bit_cnt >= slot_bits),
//   registered, so ws changes only on sck falling edges. Slot position p = bit_cnt mod slot_bits.
//  Capture (I2S one-bit delay): on rise_ev with 1 <= p <= w_sample, each line shifts sd[l] into its
//   shift register LSB. Bits with p=0 or p>w_sample (mic tristate) are ignored.
//  Slot complete on rise_ev with p == w_sample:
//   left slot: shift regs copied to left staging regs (not yet visible).
//   stereo=1, right slot: channel 2l <- left staging[l], channel 2l+1 <- shift[l]; sample_valid pulses
//    on the following clk cycle, sample registered in the same cycle as the pulse.
//   stereo=0: right slot ignored; left completion drives channel l and sample_valid directly.
//  Latency: sample_valid exactly 1 clk after the rise_ev that captured the final bit of the committing slot.
//  Startup: the first frame after reset release is discarded (mics need a ws edge to lock);
//   first sample_valid occurs in the second frame. Output rate = 1 pulse per frame.
//  sample holds its value between pulses; never partially updated.
//  Peak: on sample_valid, per channel mag = |x|; -2^(w_sample-1) saturates to 2^(w_sample-1)-1;
//   peak <= max(peak, mag). peak_clr in the same cycle as an update: peak <= mag of the new sample
//   (clear then accumulate). peak_clr otherwise: peak <= 0 next cycle.
//  Reset mid-frame: everything returns to reset values immediately; partial slot dropped, startup discard reapplies.
//  No backpressure: consumer must take sample on the pulse.
// STRUCTURE
//  Package i2s_rx_pkg: n_ch computation function, slot/left-right enum, peak saturation helper.
//  Sub-module i2s_master_clk_gen: divider, sck, ws, bit_cnt, rise_ev/fall_ev, slot position output.
//  Top level: per-line generate of shift + left staging regs, commit logic, startup-discard flag, peak array.
// TESTING  (sck_half_period=2, n_lines=2, w_sample=24, slot_bits=32, stereo=1: sck=clk/4, frame=256 clk)
//  Reset release -> sck period 4 clk, ws low for 128 clk then high for 128 clk; no sample_valid in frame 0.
//  Mic models drive L0=0x123456, R0=0xABCDEF, L1=0x7FFFFF, R1=0x800000 -> one pulse per frame at
//   1 clk after the 24th right-slot rise_ev; lanes equal those values exactly, all updated in the same cycle.
//  Same stimulus, peak check -> peak ch0=0x123456, ch1=0x543211, ch2=0x7FFFFF, ch3=0x7FFFFF (saturated).
//  sd forced 1 at p=0 and p=25..31 -> samples unchanged (delay bit and tristate bits ignored).
//  stereo=0, L0=0x000001, L1=0xFFFFFF -> 2 lanes: 0x000001, 0xFFFFFF; pulse 1 clk after left slot completes.
//  rst_n pulsed low mid right slot -> outputs 0 at once; next valid only after one discarded frame; peak_clr
//   coincident with a valid -> peak equals that sample's magnitude.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// Shared types and helpers for the multi-line I2S microphone receiver.
package i2s_rx_pkg;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  function automatic int n_ch_f(input int lines, input bit st);
    if (st) begin
      return lines + lines;
    end else begin
      return lines;
    end
  endfunction

  // |x| for a w-bit sample held sign-extended in x; the most negative code saturates.
  function automatic logic [63:0] mag_sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] most_neg;
    most_neg = -(64'sd1 <<< (w - 32'sd1));
    if (x == most_neg) begin
      return (64'd1 << (w - 32'sd1)) - 64'd1;
    end else if (x < 64'sd0) begin
      return $unsigned(-x);
    end else begin
      return $unsigned(x);
    end
  endfunction

endpackage

// File: rtl/i2s_master_clk_gen.sv
// I2S master timing: sck divider, frame bit counter, registered ws and the
// single-cycle rise/fall events every other block keys off.
module i2s_master_clk_gen
  import i2s_rx_pkg::*;
#(
  parameter int sck_half_period = 8,
  parameter int slot_bits       = 32,
  localparam int DIV_W = (sck_half_period > 32'sd1) ? $clog2(sck_half_period) : 32'sd1,
  localparam int BC_W  = $clog2(slot_bits + slot_bits),
  localparam int POS_W = $clog2(slot_bits)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             sck,
  output logic             ws,
  output logic             rise_ev,
  output logic             fall_ev,
  output logic [POS_W-1:0] slot_pos,
  output slot_e            slot
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(sck_half_period - 32'sd1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(slot_bits + slot_bits - 32'sd1);
  localparam logic [BC_W-1:0]  SLOT_LEN = BC_W'(slot_bits);

  logic [DIV_W-1:0] div_cnt_r;
  logic             sck_r;
  logic             ws_r;
  logic [BC_W-1:0]  bit_cnt_r;
  logic [BC_W-1:0]  bit_cnt_nxt_s;
  logic [BC_W-1:0]  pos_full_s;
  logic             wrap_s;
  logic             in_right_s;

  // Edge events, next bit count and slot position decode.
  always_comb begin
    wrap_s  = (div_cnt_r == DIV_LAST);
    rise_ev = wrap_s & ~sck_r;
    fall_ev = wrap_s & sck_r;
    if (bit_cnt_r == BIT_LAST) begin
      bit_cnt_nxt_s = '0;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + BC_W'(1'b1);
    end
    in_right_s = (bit_cnt_r >= SLOT_LEN);
    if (in_right_s) begin
      pos_full_s = bit_cnt_r - SLOT_LEN;
      slot       = SLOT_RIGHT;
    end else begin
      pos_full_s = bit_cnt_r;
      slot       = SLOT_LEFT;
    end
    slot_pos = POS_W'(pos_full_s);
  end

  // Divider, sck toggle and bit counter; ws follows the new count on sck falls only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      sck_r     <= 1'b0;
      ws_r      <= 1'b0;
      bit_cnt_r <= '0;
    end else begin
      if (wrap_s) begin
        div_cnt_r <= '0;
        sck_r     <= ~sck_r;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
      end
      if (fall_ev) begin
        bit_cnt_r <= bit_cnt_nxt_s;
        ws_r      <= (bit_cnt_nxt_s >= SLOT_LEN);
      end
    end
  end

  assign sck = sck_r;
  assign ws  = ws_r;

endmodule

// File: rtl/i2s_multi_mic_receiver.sv
// Multi-line I2S master receiver: per-line slot capture, frame-aligned commit of
// all channels with one valid strobe, and per-channel peak magnitude tracking.
module i2s_multi_mic_receiver
  import i2s_rx_pkg::*;
#(
  parameter int sck_half_period = 8,
  parameter int n_lines         = 2,
  parameter int w_sample        = 24,
  parameter int slot_bits       = 32,
  parameter bit stereo          = 1'b1,
  localparam int N_CH   = n_ch_f(n_lines, stereo),
  localparam int PEAK_W = w_sample - 32'sd1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       sck,
  output logic                       ws,
  input  logic [n_lines-1:0]         sd,
  input  logic                       peak_clr,
  output logic [N_CH*w_sample-1:0]   sample,
  output logic                       sample_valid,
  output logic [N_CH*PEAK_W-1:0]     peak
);

  localparam int POS_W = $clog2(slot_bits);
  localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1'b1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(w_sample);
  localparam logic [POS_W-1:0] POS_END   = POS_W'(slot_bits - 32'sd1);

  logic             rise_ev_s;
  logic             fall_ev_s;
  logic [POS_W-1:0] slot_pos_s;
  slot_e            slot_s;
  logic             capture_s;
  logic             slot_done_s;
  logic             frame_end_s;
  logic             commit_s;
  logic             armed_r;

  // The final bit of a slot comes straight from sd, so only w_sample-1 bits are stored.
  logic [PEAK_W-1:0]   shift_r     [n_lines];
  logic [w_sample-1:0] shift_nxt_s [n_lines];
  logic [w_sample-1:0] lanes_s     [N_CH];
  logic [PEAK_W-1:0]   mag_s       [N_CH];
  logic [PEAK_W-1:0]   peak_r      [N_CH];

  i2s_master_clk_gen #(
    .sck_half_period(sck_half_period),
    .slot_bits      (slot_bits)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .ws      (ws),
    .rise_ev (rise_ev_s),
    .fall_ev (fall_ev_s),
    .slot_pos(slot_pos_s),
    .slot    (slot_s)
  );

  // Capture window, slot completion and frame-level commit decision.
  always_comb begin
    capture_s   = rise_ev_s && (slot_pos_s >= POS_FIRST) && (slot_pos_s <= POS_LAST);
    slot_done_s = rise_ev_s && (slot_pos_s == POS_LAST);
    frame_end_s = fall_ev_s && (slot_s == SLOT_RIGHT) && (slot_pos_s == POS_END);
    if (stereo) begin
      commit_s = slot_done_s && armed_r && (slot_s == SLOT_RIGHT);
    end else begin
      commit_s = slot_done_s && armed_r && (slot_s == SLOT_LEFT);
    end
  end

  for (genvar l = 0; l < n_lines; l++) begin : g_line
    assign shift_nxt_s[l] = {shift_r[l], sd[l]};

    // Per-line serial shift register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shift_r[l] <= '0;
      end else if (capture_s) begin
        shift_r[l] <= shift_nxt_s[l][PEAK_W-1:0];
      end
    end

    if (stereo) begin : g_stereo
      logic [w_sample-1:0] stage_r;

      // Left word parked here until the right slot of the same frame completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_r <= '0;
        end else if (slot_done_s && (slot_s == SLOT_LEFT)) begin
          stage_r <= shift_nxt_s[l];
        end
      end

      assign lanes_s[2*l]     = stage_r;
      assign lanes_s[2*l + 1] = shift_nxt_s[l];
    end else begin : g_mono
      assign lanes_s[l] = shift_nxt_s[l];
    end
  end

  // Startup discard flag, sample commit and valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r      <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      if (frame_end_s) begin
        armed_r <= 1'b1;
      end
      sample_valid <= commit_s;
      if (commit_s) begin
        for (int c = 0; c < N_CH; c++) begin
          sample[c*w_sample +: w_sample] <= lanes_s[c];
        end
      end
    end
  end

  // Saturated magnitude of each committed lane.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      mag_s[c] = PEAK_W'(mag_sat(64'($signed(sample[c*w_sample +: w_sample])), w_sample));
    end
  end

  // Peak hold; a clear coinciding with an update restarts from the new magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        peak_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (sample_valid) begin
          if (peak_clr || (mag_s[c] > peak_r[c])) begin
            peak_r[c] <= mag_s[c];
          end
        end else if (peak_clr) begin
          peak_r[c] <= '0;
        end
      end
    end
  end

  // Flatten the peak array onto the output bus.
  always_comb begin
    peak = '0;
    for (int c = 0; c < N_CH; c++) begin
      peak[c*PEAK_W +: PEAK_W] = peak_r[c];
    end
  end

endmodule

// File: tb/tb_i2s_multi_mic_receiver.sv
// Bench for i2s_multi_mic_receiver: a stereo and a mono instance fed by mic models,
// checked every cycle against a frame-timing/value model plus literal spot checks.
module tb_i2s_multi_mic_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        peak_clr;
  logic        sck0, ws0, valid0, sck1, ws1, valid1;
  logic [1:0]  sd0, sd1;
  logic [95:0] sample0;
  logic [91:0] peak0;
  logic [47:0] sample1;
  logic [45:0] peak1;

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [23:0] wl [2];
  logic [23:0] wr [2];
  logic [23:0] w1l [2];
  logic        junk;

  i2s_multi_mic_receiver #(
    .sck_half_period(2), .n_lines(2), .w_sample(24), .slot_bits(32), .stereo(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck0), .ws(ws0), .sd(sd0), .peak_clr(peak_clr),
    .sample(sample0), .sample_valid(valid0), .peak(peak0)
  );

  i2s_multi_mic_receiver #(
    .sck_half_period(2), .n_lines(2), .w_sample(24), .slot_bits(32), .stereo(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck1), .ws(ws1), .sd(sd1), .peak_clr(peak_clr),
    .sample(sample1), .sample_valid(valid1), .peak(peak1)
  );

  always #5 clk = ~clk;

  // Clock cycles since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mag24(input logic [23:0] v);
    int sv;
    sv = int'($signed(v));
    if (sv == -8388608) return 8388607;
    return (sv < 0) ? -sv : sv;
  endfunction

  function automatic logic mic_bit(input int k, input logic [23:0] w, input logic j);
    if (k >= 1 && k <= 24) return w[24 - k];
    return j;
  endfunction

  // Mic models: react to sck falls like a real mic, MSB one sck after each ws edge.
  initial begin : mic
    int k;
    logic pws, psck;
    k = 0; pws = 1'b0; psck = 1'b0; sd0 = '0; sd1 = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        k = 0; pws = 1'b0; psck = 1'b0;
      end else begin
        if (psck && !sck0) begin
          if (ws0 != pws) k = 0;
          else            k++;
          pws = ws0;
        end
        psck = sck0;
      end
      for (int l = 0; l < 2; l++) begin
        sd0[l] = mic_bit(k, ws0 ? wr[l] : wl[l], junk);
        sd1[l] = mic_bit(k, ws0 ? 24'h5A5A5A : w1l[l], junk);
      end
    end
  end

  // Reference model and per-cycle comparison on the falling clock edge.
  initial begin : cmp
    logic [95:0] exp_s0;
    logic [47:0] exp_s1;
    int exp_p0 [4];
    int exp_p1 [2];
    logic ev0, ev1, e_sck, e_ws;
    int m;
    exp_s0 = '0; exp_s1 = '0;
    for (int c = 0; c < 4; c++) exp_p0[c] = 0;
    for (int c = 0; c < 2; c++) exp_p1[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_s0 = '0; exp_s1 = '0;
        for (int c = 0; c < 4; c++) exp_p0[c] = 0;
        for (int c = 0; c < 2; c++) exp_p1[c] = 0;
        chk("rst_sck", {sck0, sck1}, 96'd0);
        chk("rst_ws", {ws0, ws1}, 96'd0);
        chk("rst_valid", {valid0, valid1}, 96'd0);
        chk("rst_sample0", sample0, 96'd0);
        chk("rst_peak0", 96'(peak0), 96'd0);
        chk("rst_sample1", 96'(sample1), 96'd0);
        chk("rst_peak1", 96'(peak1), 96'd0);
      end else begin
        e_sck = ((cyc / 2) % 2) == 1;
        e_ws  = ((cyc / 4) % 64) >= 32;
        ev0   = (cyc >= 256) && ((cyc % 256) == 226);
        ev1   = (cyc >= 256) && ((cyc % 256) == 98);
        chk("sck0", sck0, e_sck);
        chk("ws0", ws0, e_ws);
        chk("sck1", sck1, e_sck);
        chk("ws1", ws1, e_ws);
        chk("valid0", valid0, ev0);
        chk("valid1", valid1, ev1);
        if (ev0)
          for (int l = 0; l < 2; l++) begin
            exp_s0[(2*l)*24 +: 24]   = wl[l];
            exp_s0[(2*l+1)*24 +: 24] = wr[l];
          end
        if (ev1)
          for (int l = 0; l < 2; l++) exp_s1[l*24 +: 24] = w1l[l];
        chk("sample0", sample0, exp_s0);
        chk("sample1", 96'(sample1), 96'(exp_s1));
        for (int c = 0; c < 4; c++) chk("peak0", 96'(peak0[c*23 +: 23]), 96'(exp_p0[c]));
        for (int c = 0; c < 2; c++) chk("peak1", 96'(peak1[c*23 +: 23]), 96'(exp_p1[c]));
        for (int c = 0; c < 4; c++) begin
          m = mag24(exp_s0[c*24 +: 24]);
          if (ev0)           exp_p0[c] = (peak_clr || m > exp_p0[c]) ? m : exp_p0[c];
          else if (peak_clr) exp_p0[c] = 0;
        end
        for (int c = 0; c < 2; c++) begin
          m = mag24(exp_s1[c*24 +: 24]);
          if (ev1)           exp_p1[c] = (peak_clr || m > exp_p1[c]) ? m : exp_p1[c];
          else if (peak_clr) exp_p1[c] = 0;
        end
      end
    end
  end

  task automatic go_to(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (cyc != target) begin
      total++; bad++;
      $display("FAIL go_to: reached cycle %0d expected %0d", cyc, target);
    end
  endtask

  task automatic lit_peak0(input string name, input logic [22:0] p3, input logic [22:0] p2,
                           input logic [22:0] p1, input logic [22:0] p0);
    chk(name, 96'(peak0), 96'({p3, p2, p1, p0}));
  endtask

  initial begin : stim
    rst_n = 1'b0; peak_clr = 1'b0; junk = 1'b0;
    wl[0] = 24'h123456; wr[0] = 24'hABCDEF; wl[1] = 24'h7FFFFF; wr[1] = 24'h800000;
    w1l[0] = 24'h000001; w1l[1] = 24'hFFFFFF;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    go_to(760);
    chk("lit_sample_a", sample0, 96'h800000_7FFFFF_ABCDEF_123456);
    lit_peak0("lit_peak_a", 23'h7FFFFF, 23'h7FFFFF, 23'h543211, 23'h123456);
    chk("lit_mono_sample", 96'(sample1), 96'h000000000000_FFFFFF_000001);
    chk("lit_mono_peak", 96'(peak1), 96'({23'd1, 23'd1}));

    // Drive 1 on the delay bit and tristate bits; captured words must not change.
    junk = 1'b1;
    go_to(1272);
    chk("lit_sample_junk", sample0, 96'h800000_7FFFFF_ABCDEF_123456);

    wl[0] = 24'h000000; wr[0] = 24'hFFFFFE; wl[1] = 24'hC00001; wr[1] = 24'h000010;
    go_to(1506);
    peak_clr = 1'b1;
    go_to(1507);
    peak_clr = 1'b0;
    go_to(1530);
    chk("lit_sample_b", sample0, 96'h000010_C00001_FFFFFE_000000);
    lit_peak0("lit_peak_clr_upd", 23'h000010, 23'h3FFFFF, 23'h000002, 23'h000000);
    chk("lit_mono_peak_clr", 96'(peak1), 96'd0);

    go_to(1600);
    peak_clr = 1'b1;
    go_to(1601);
    peak_clr = 1'b0;
    go_to(1610);
    lit_peak0("lit_peak_cleared", 23'd0, 23'd0, 23'd0, 23'd0);

    // Reset in the middle of the right slot.
    go_to(1716);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_sample0", sample0, 96'd0);
    chk("lit_rst_valid", {valid0, valid1}, 96'd0);
    chk("lit_rst_sample1", 96'(sample1), 96'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    go_to(300);
    chk("lit_after_rst_discard", sample0, 96'd0);
    go_to(600);
    chk("lit_after_rst_sample", sample0, 96'h000010_C00001_FFFFFE_000000);
    lit_peak0("lit_after_rst_peak", 23'h000010, 23'h3FFFFF, 23'h000002, 23'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
